// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and its datapath/caches.
// The count preload pair lets the retired-instruction counter be set to a known value.
interface stage_sequencer_if;
    logic        run;
    logic        instrReady;
    logic        memReady;
    logic        memRead;
    logic        memWrite;
    logic        regWriteFlag;
    logic        branch;
    logic        unconditionalBranch;
    logic        countLoad;
    logic [15:0] countLoadValue;

    logic        instrReq;
    logic        irLoad;
    logic        aluEnable;
    logic        memReq;
    logic        memWriteEnable;
    logic        regWriteEnable;
    logic        pcUpdate;
    logic [2:0]  stage;
    logic [15:0] instrCount;
    logic        error;

    modport slave (
        input  run, instrReady, memReady, memRead, memWrite, regWriteFlag,
               branch, unconditionalBranch, countLoad, countLoadValue,
        output instrReq, irLoad, aluEnable, memReq, memWriteEnable,
               regWriteEnable, pcUpdate, stage, instrCount, error
    );

    modport master (
        output run, instrReady, memReady, memRead, memWrite, regWriteFlag,
               branch, unconditionalBranch, countLoad, countLoadValue,
        input  instrReq, irLoad, aluEnable, memReq, memWriteEnable,
               regWriteEnable, pcUpdate, stage, instrCount, error
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: fetch/decode/execute/memory/writeback
// with a 15-cycle ready timeout on fetch and memory that parks in a sticky ERROR.
module stage_sequencer (
    input  logic              i_clock,
    input  logic              i_reset,
    stage_sequencer_if.slave  io_seq
);
    // state     | meaning
    // IDLE      | waiting for run
    // FETCH     | instruction request outstanding
    // DECODE    | one-cycle decode gap
    // EXECUTE   | ALU strobe, decoder flags latched
    // MEMORY    | data request outstanding
    // WRITEBACK | register file write
    // ERROR     | ready timeout, held until reset
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        ERROR     = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'd14;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [15:0] r_instr_count;

    logic        w_wait_inc;
    logic        w_latch;
    logic        w_retire;
    logic        w_instr_req;
    logic        w_ir_load;
    logic        w_alu_enable;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_reg_we;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_wait        <= 4'd0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_instr_count <= 16'd0;
        end else begin
            r_state <= w_state_next;
            // Every state change clears the wait count, which covers entry to FETCH and MEMORY.
            if (w_state_next != r_state)
                r_wait <= 4'd0;
            else if (w_wait_inc)
                r_wait <= r_wait + 4'd1;
            if (w_latch) begin
                r_mem_read  <= io_seq.memRead;
                r_mem_write <= io_seq.memWrite;
            end
            if (io_seq.countLoad)
                r_instr_count <= io_seq.countLoadValue;
            else if (w_retire)
                r_instr_count <= r_instr_count + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_inc   = 1'b0;
        w_latch      = 1'b0;
        w_retire     = 1'b0;
        w_instr_req  = 1'b0;
        w_ir_load    = 1'b0;
        w_alu_enable = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_reg_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_seq.run)
                    w_state_next = FETCH;
            end
            FETCH: begin
                w_instr_req = 1'b1;
                if (io_seq.instrReady) begin
                    w_ir_load    = 1'b1;
                    w_state_next = DECODE;
                end else if (r_wait == WAIT_LIMIT) begin
                    w_state_next = ERROR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            DECODE: begin
                w_state_next = EXECUTE;
            end
            EXECUTE: begin
                w_alu_enable = 1'b1;
                w_latch      = 1'b1;
                if (io_seq.memRead || io_seq.memWrite)
                    w_state_next = MEMORY;
                else if (io_seq.branch || io_seq.unconditionalBranch)
                    w_retire = 1'b1;
                else if (io_seq.regWriteFlag)
                    w_state_next = WRITEBACK;
                else
                    w_retire = 1'b1;
            end
            MEMORY: begin
                w_mem_req = 1'b1;
                w_mem_we  = r_mem_write;
                // A read with the write flag also set is a store: no writeback.
                if (io_seq.memReady) begin
                    if (r_mem_read && !r_mem_write)
                        w_state_next = WRITEBACK;
                    else
                        w_retire = 1'b1;
                end else if (r_wait == WAIT_LIMIT) begin
                    w_state_next = ERROR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            WRITEBACK: begin
                w_reg_we = 1'b1;
                w_retire = 1'b1;
            end
            ERROR: begin
                w_state_next = ERROR;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_retire)
            w_state_next = io_seq.run ? FETCH : IDLE;
    end

    assign io_seq.instrReq       = w_instr_req;
    assign io_seq.irLoad         = w_ir_load;
    assign io_seq.aluEnable      = w_alu_enable;
    assign io_seq.memReq         = w_mem_req;
    assign io_seq.memWriteEnable = w_mem_we;
    assign io_seq.regWriteEnable = w_reg_we;
    assign io_seq.pcUpdate       = w_retire;
    assign io_seq.stage          = r_state;
    assign io_seq.instrCount     = r_instr_count;
    assign io_seq.error          = (r_state == ERROR);
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; no other reset exists.
REQ-003 run  in  1  permit to start the next instruction.
REQ-004 instrReady  in  1  instruction cache ack.
REQ-005 memReady  in  1  data cache ack.
REQ-006 memRead, memWrite, regWriteFlag, branch, unconditionalBranch  in  1 each  decoder flags.
REQ-007 instrReq  out  1  instruction fetch request.
REQ-008 irLoad  out  1  load instruction register.
REQ-009 aluEnable  out  1  ALU evaluate strobe.
REQ-010 memReq  out  1  data cache request.
REQ-011 memWriteEnable  out  1  store qualifier.
REQ-012 regWriteEnable  out  1  register file write strobe.
REQ-013 pcUpdate  out  1  instruction retire, PC advance.
REQ-014 stage  out  3  current state code.
REQ-015 instrCount  out  16  retired instruction count.
REQ-016 error  out  1  sticky timeout flag.

Function
REQ-017 States and stage codes SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=7; code 6 is unused and SHALL go to IDLE.
REQ-018 IDLE: all strobes low; run=1 -> FETCH, else stay.
REQ-019 FETCH: instrReq=1; instrReady=1 -> irLoad=1 in the same cycle, then DECODE; else stay.
REQ-020 DECODE SHALL last exactly one cycle with all strobes low, then EXECUTE.
REQ-021 EXECUTE: aluEnable=1 for one cycle; the decoder flags SHALL be sampled and latched here for use in MEMORY and WRITEBACK.
REQ-022 EXECUTE exit priority: (memRead|memWrite) -> MEMORY; else if branch|unconditionalBranch -> retire; else if regWriteFlag -> WRITEBACK; else retire.
REQ-023 MEMORY: memReq=1 and memWriteEnable=latched memWrite; on memReady=1 either latched memRead=1 and memWrite=0 -> WRITEBACK, or otherwise retire.
REQ-024 memRead and memWrite both set SHALL be treated as a store: no WRITEBACK.
REQ-025 WRITEBACK: regWriteEnable=1 for one cycle, then retire.
REQ-026 Retire: pcUpdate=1 for exactly one cycle per instruction, in the instruction's final state cycle; instrCount+1 on the same edge; next state FETCH if run=1 else IDLE.
REQ-027 instrCount SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-028 Minimum latency FETCH to retire, zero-wait: ALU-only 3 cycles, ALU+WB 4, store 4, load 5.
REQ-029 run deasserted mid-instruction SHALL NOT abort it; the instruction retires, then the block goes to IDLE.
REQ-030 Wait counter (4-bit): cleared on entry to FETCH or MEMORY; +1 per cycle the state holds without its ready signal.
REQ-031 When the wait counter would reach 15 without ready, the block SHALL go to ERROR; ready in that same cycle wins and no error occurs.
REQ-032 ERROR: all strobes low, error=1, stage=7; held until reset.
REQ-033 Strobes SHALL be state-decoded (irLoad and the MEMORY exit use ready combinationally); no strobe SHALL be active outside its state.

Reset
REQ-034 On reset assertion, at any time and independent of clock: state=IDLE, all strobes 0, stage=0, instrCount=0, error=0, wait counter=0, latched flags=0.
REQ-035 Reset asserted mid-MEMORY SHALL drop memReq immediately; no pcUpdate is issued for the aborted instruction.

Verification
REQ-036 ADD path: run=1, instrReady=1 first cycle, regWriteFlag=1 -> stage 1,2,3,5; regWriteEnable and pcUpdate high in cycle 4; instrCount=1.
REQ-037 Load with 3 wait cycles: memRead=1, memReady high on the 4th MEMORY cycle -> memReq high 4 cycles, then WRITEBACK; total 8 cycles; pcUpdate once.
REQ-038 Branch: branch=1, regWriteFlag=0 -> pcUpdate in EXECUTE; no MEMORY or WRITEBACK; next stage=1 with run=1.
REQ-039 Timeout: instrReady held 0 -> stage=7 and error=1 after 15 FETCH cycles; instrReady=1 on exactly the 15th cycle -> DECODE, error=0.
REQ-040 instrCount preset at 0xFFFF, retire one store (memWrite=1) -> memWriteEnable=1 in MEMORY, no regWriteEnable, instrCount=0x0000.
REQ-041 Asynchronous reset pulse between clock edges during MEMORY -> stage=0, memReq=0 before the next edge; instrCount unchanged by the aborted instruction.
